// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carried out of fifo_rd_stream.
// master drives data and valid; slave (the sink) drives ready.
`timescale 1ns/1ps

interface fifo_rd_stream_if #(
    parameter int BITS = 32
);
    logic            m_valid;
    logic            m_ready;
    logic [BITS-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-end adapter: async-FIFO read port (1-cycle registered data) to valid/ready stream.
// Optional statistics counters are enabled with `define FIFO_RD_STREAM_STATS_EN.
`timescale 1ns/1ps

module fifo_rd_stream #(
    parameter int BITS = 32
) (
    input  logic            rd_clk,
    input  logic            rd_rst_n,
    output logic            fifo_rd_en,
    input  logic [BITS-1:0] fifo_rd_data,
    input  logic            fifo_rd_empty,
    fifo_rd_stream_if.master m,
    input  logic            flush,
    output logic            flush_done
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [31:0]     stat_words,
    output logic [31:0]     stat_stall
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      count_q, count_d;
    logic [1:0]      head_q, head_d;
    logic [1:0]      tail_q, tail_d;
    logic            pending_q;
    logic            flush_done_q;
    logic [BITS-1:0] buf_q [3];

    logic            m_valid_int;
    logic            push;
    logic            pop;
    logic            rd_accept;
    logic            drain_exit;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // The read request looks only at registered occupancy, so m_ready never
    // reaches fifo_rd_en combinationally; three entries cover the round trip.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned (which would infer a latch).
        state_d     = state_q;
        count_d     = count_q;
        head_d      = head_q;
        tail_d      = tail_q;
        push        = 1'b0;
        pop         = 1'b0;
        drain_exit  = 1'b0;
        fifo_rd_en  = 1'b0;
        m_valid_int = 1'b0;

        unique case (state_q)
            RUN: begin
                m_valid_int = (count_q != 2'd0);
                fifo_rd_en  = !fifo_rd_empty &&
                              (({1'b0, count_q} + {2'b00, pending_q}) < 3'd3);
                pop         = m_valid_int && m.m_ready;
                push        = pending_q && !flush;

                if (flush) begin
                    state_d = DRAIN;
                    count_d = 2'd0;
                    head_d  = tail_q;
                end else begin
                    if (push) tail_d = ptr_inc(tail_q);
                    if (pop)  head_d = ptr_inc(head_q);
                    unique case ({push, pop})
                        2'b10:   count_d = count_q + 2'd1;
                        2'b01:   count_d = count_q - 2'd1;
                        default: count_d = count_q;
                    endcase
                end
            end

            DRAIN: begin
                fifo_rd_en = !fifo_rd_empty;
                if (fifo_rd_empty && !pending_q) begin
                    drain_exit = 1'b1;
                    state_d    = RUN;
                end
            end

            default: state_d = RUN;
        endcase

        if (!rd_rst_n) fifo_rd_en = 1'b0;
    end

    assign rd_accept   = fifo_rd_en && !fifo_rd_empty;
    assign m.m_valid   = m_valid_int;
    assign m.m_data    = buf_q[head_q];
    assign flush_done  = flush_done_q;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q      <= RUN;
            count_q      <= 2'd0;
            head_q       <= 2'd0;
            tail_q       <= 2'd0;
            pending_q    <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of statement order.
            state_q      <= state_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            pending_q    <= rd_accept;
            flush_done_q <= drain_exit;
        end
    end

    // NOTE: the buffer is reset because m_data reads it directly and must be
    // zero out of reset; at three entries this is cheap.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
        end else if (push) begin
            buf_q[tail_q] <= fifo_rd_data;
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    // Saturating delivery and back-pressure counters; flush leaves them alone.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else begin
            if (m_valid_int && m.m_ready && (stat_words != 32'hFFFF_FFFF))
                stat_words <= stat_words + 32'd1;
            if (m_valid_int && !m.m_ready && (stat_stall != 32'hFFFF_FFFF))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

    a_no_overflow: assert property (
        @(posedge rd_clk) disable iff (!rd_rst_n) !(push && (count_q == 2'd3))
    );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream with a behavioural FIFO read port.
// Define FIFO_RD_STREAM_STATS_EN to also exercise the statistics counters.
`timescale 1ns/1ps

module tb_fifo_rd_stream;

    localparam int BITS = 32;

    logic            rd_clk = 1'b0;
    logic            rd_rst_n;
    logic            fifo_rd_en;
    logic [BITS-1:0] fifo_rd_data = '0;
    logic            fifo_rd_empty;
    logic            flush;
    logic            flush_done;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [31:0]     stat_words;
    logic [31:0]     stat_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fifo_rd_stream_if #(.BITS(BITS)) m_if ();

    fifo_rd_stream #(.BITS(BITS)) dut (
        .rd_clk        (rd_clk),
        .rd_rst_n      (rd_rst_n),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .m             (m_if),
        .flush         (flush),
        .flush_done    (flush_done)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .stat_words    (stat_words),
        .stat_stall    (stat_stall)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    // Behavioural FIFO read port: registered data, one word per accepted read.
    logic [BITS-1:0] fifo_mem [0:255];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int n_reads = 0;

    assign fifo_rd_empty = (rd_ptr == wr_ptr);

    always @(posedge rd_clk) begin
        if (fifo_rd_en && !fifo_rd_empty) begin
            fifo_rd_data <= fifo_mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
            n_reads      <= n_reads + 1;
        end
    end

    task automatic fifo_load(input logic [BITS-1:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset();
        rd_rst_n = 1'b0;
        flush = 1'b0;
        m_if.m_ready = 1'b0;
        fifo_load(32'h1);
        repeat (3) @(negedge rd_clk);
        n_checks++;
        if (fifo_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en);
        end
        n_checks++;
        if (m_if.m_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_if.m_valid);
        end
        n_checks++;
        if (m_if.m_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_m_data: got %h expected 0", m_if.m_data);
        end
        n_checks++;
        if (flush_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flush_done: got %b expected 0", flush_done);
        end
        rd_rst_n = 1'b1;
        #1;
        n_checks++;
        if (fifo_rd_en !== 1'b1) begin
            n_fail++; $display("FAIL first_rd_en: got %b expected 1", fifo_rd_en);
        end
        @(negedge rd_clk);
        n_checks++;
        if (m_if.m_valid !== 1'b0) begin
            n_fail++; $display("FAIL latency_cycle1_valid: got %b expected 0", m_if.m_valid);
        end
        @(negedge rd_clk);
        n_checks++;
        if (m_if.m_valid !== 1'b1 || m_if.m_data !== 32'h1) begin
            n_fail++;
            $display("FAIL latency_cycle2: got valid=%b data=%h expected valid=1 data=1",
                     m_if.m_valid, m_if.m_data);
        end
        m_if.m_ready = 1'b1;
        @(negedge rd_clk);
        m_if.m_ready = 1'b0;
        n_checks++;
        if (m_if.m_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_after_pop_valid: got %b expected 0", m_if.m_valid);
        end
    endtask

    task automatic test_stream();
        int idx = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        int bad_en = 0;
        m_if.m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) fifo_load(BITS'(i));
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge rd_clk);
            if (fifo_rd_empty && fifo_rd_en) bad_en++;
            if (m_if.m_valid && m_if.m_ready) begin
                n_checks++;
                if (m_if.m_data !== BITS'(idx + 1)) begin
                    n_fail++;
                    $display("FAIL stream_beat%0d: got %h expected %h",
                             idx, m_if.m_data, BITS'(idx + 1));
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                idx++;
                if (idx == 16) break;
            end
        end
        n_checks++;
        if (idx != 16) begin
            n_fail++; $display("FAIL stream_count: got %0d expected 16", idx);
        end
        n_checks++;
        if (first_cyc != 1) begin
            n_fail++; $display("FAIL stream_latency: got cycle %0d expected 1", first_cyc);
        end
        n_checks++;
        if (last_cyc - first_cyc != 15) begin
            n_fail++; $display("FAIL stream_no_bubble: got span %0d expected 15",
                               last_cyc - first_cyc);
        end
        n_checks++;
        if (bad_en != 0) begin
            n_fail++; $display("FAIL stream_rd_en_when_empty: got %0d cycles expected 0", bad_en);
        end
        @(negedge rd_clk);
        n_checks++;
        if (m_if.m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_idle: got valid=%b rd_en=%b expected 0 0",
                     m_if.m_valid, fifo_rd_en);
        end
        m_if.m_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int base;
        int idx = 0;
        base = n_reads;
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_load(32'h21 + BITS'(i));
        repeat (10) @(negedge rd_clk);
        n_checks++;
        if (n_reads - base != 3) begin
            n_fail++; $display("FAIL bp_reads: got %0d expected 3", n_reads - base);
        end
        n_checks++;
        if (fifo_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL bp_rd_en: got %b expected 0", fifo_rd_en);
        end
        n_checks++;
        if (m_if.m_valid !== 1'b1 || m_if.m_data !== 32'h21) begin
            n_fail++;
            $display("FAIL bp_head: got valid=%b data=%h expected valid=1 data=21",
                     m_if.m_valid, m_if.m_data);
        end
        @(negedge rd_clk);
        n_checks++;
        if (m_if.m_data !== 32'h21) begin
            n_fail++; $display("FAIL bp_head_stable: got %h expected 21", m_if.m_data);
        end
        m_if.m_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (m_if.m_valid) begin
                n_checks++;
                if (m_if.m_data !== 32'h21 + BITS'(idx)) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: got %h expected %h",
                             idx, m_if.m_data, 32'h21 + BITS'(idx));
                end
                idx++;
            end
            @(negedge rd_clk);
            if (idx == 8) break;
        end
        n_checks++;
        if (idx != 8) begin
            n_fail++; $display("FAIL bp_count: got %0d expected 8", idx);
        end
        m_if.m_ready = 1'b0;
    endtask

    task automatic test_toggle();
        int idx = 0;
        bit prev_stall = 1'b0;
        logic [BITS-1:0] held = '0;
        m_if.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) fifo_load(32'hA0 + BITS'(i));
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge rd_clk);
            if (prev_stall) begin
                n_checks++;
                if (m_if.m_data !== held) begin
                    n_fail++; $display("FAIL toggle_hold: got %h expected %h", m_if.m_data, held);
                end
            end
            m_if.m_ready = ~m_if.m_ready;
            prev_stall = m_if.m_valid && !m_if.m_ready;
            held = m_if.m_data;
            if (m_if.m_valid && m_if.m_ready) begin
                n_checks++;
                if (m_if.m_data !== 32'hA0 + BITS'(idx)) begin
                    n_fail++;
                    $display("FAIL toggle_beat%0d: got %h expected %h",
                             idx, m_if.m_data, 32'hA0 + BITS'(idx));
                end
                idx++;
                if (idx == 16) break;
            end
        end
        n_checks++;
        if (idx != 16) begin
            n_fail++; $display("FAIL toggle_count: got %0d expected 16", idx);
        end
        @(negedge rd_clk);
        m_if.m_ready = 1'b0;
        n_checks++;
        if (m_if.m_valid !== 1'b0) begin
            n_fail++; $display("FAIL toggle_idle: got %b expected 0", m_if.m_valid);
        end
    endtask

    task automatic test_flush();
        int base;
        int valid_err = 0;
        bit seen = 1'b0;
        bit got = 1'b0;
        base = n_reads;
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 13; i++) fifo_load(32'hC0 + BITS'(i));
        repeat (8) @(negedge rd_clk);
        n_checks++;
        if (n_reads - base != 3 || m_if.m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_prefill: got reads=%0d valid=%b expected 3 1",
                     n_reads - base, m_if.m_valid);
        end
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        n_checks++;
        if (m_if.m_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_valid_drop: got %b expected 0", m_if.m_valid);
        end
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge rd_clk);
            if (m_if.m_valid) valid_err++;
            if (flush_done) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL flush_done_seen: got 0 expected 1");
        end
        n_checks++;
        if (n_reads - base != 13 || fifo_rd_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_drained: got reads=%0d empty=%b expected 13 1",
                     n_reads - base, fifo_rd_empty);
        end
        n_checks++;
        if (valid_err != 0) begin
            n_fail++; $display("FAIL flush_valid_during_drain: got %0d expected 0", valid_err);
        end
        @(negedge rd_clk);
        n_checks++;
        if (flush_done !== 1'b0) begin
            n_fail++; $display("FAIL flush_done_pulse: got %b expected 0", flush_done);
        end
        fifo_load(32'h55);
        m_if.m_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge rd_clk);
            if (m_if.m_valid) begin
                got = 1'b1;
                n_checks++;
                if (m_if.m_data !== 32'h55) begin
                    n_fail++; $display("FAIL flush_next_word: got %h expected 55", m_if.m_data);
                end
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL flush_next_seen: got 0 expected 1");
        end
        @(negedge rd_clk);
        m_if.m_ready = 1'b0;
        n_checks++;
        if (m_if.m_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_next_idle: got %b expected 0", m_if.m_valid);
        end
    endtask

`ifdef FIFO_RD_STREAM_STATS_EN
    task automatic test_stats();
        int beats = 0;
        int stalls = 0;
        bit seen = 1'b0;
        m_if.m_ready = 1'b0;
        rd_rst_n = 1'b0;
        @(negedge rd_clk);
        n_checks++;
        if (stat_words !== 32'd0 || stat_stall !== 32'd0) begin
            n_fail++;
            $display("FAIL stats_reset: got words=%0d stall=%0d expected 0 0",
                     stat_words, stat_stall);
        end
        rd_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) fifo_load(32'h61 + BITS'(i));
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge rd_clk);
            if (m_if.m_valid) begin
                if (stalls < 2) begin
                    m_if.m_ready = 1'b0;
                    stalls++;
                end else begin
                    m_if.m_ready = 1'b1;
                end
            end
            if (m_if.m_valid && m_if.m_ready) beats++;
            if (beats == 5) break;
        end
        @(negedge rd_clk);
        m_if.m_ready = 1'b0;
        n_checks++;
        if (stat_words !== 32'd5 || stat_stall !== 32'd2) begin
            n_fail++;
            $display("FAIL stats_counts: got words=%0d stall=%0d expected 5 2",
                     stat_words, stat_stall);
        end
        flush = 1'b1;
        @(negedge rd_clk);
        flush = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge rd_clk);
            if (flush_done) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL stats_flush_done: got 0 expected 1");
        end
        n_checks++;
        if (stat_words !== 32'd5 || stat_stall !== 32'd2) begin
            n_fail++;
            $display("FAIL stats_after_flush: got words=%0d stall=%0d expected 5 2",
                     stat_words, stat_stall);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_flush();
`ifdef FIFO_RD_STREAM_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
